// File: rtl/block_connect_if.sv
// I/Q sample bus for block_connect: input samples and rotated/averaged outputs.
interface block_connect_if #(
    parameter int DW = 16
);
    logic signed [DW-1:0] x_i;
    logic signed [DW-1:0] x_q;
    logic signed [DW-1:0] y_out_i;
    logic signed [DW-1:0] y_out_q;

    modport master (
        output x_i,
        output x_q,
        input  y_out_i,
        input  y_out_q
    );

    modport slave (
        input  x_i,
        input  x_q,
        output y_out_i,
        output y_out_q
    );
endinterface

// File: rtl/block_connect.sv
// I/Q chain: 4-deep delay line, 4-tap floor moving average, optional fs/4 rotator.
// Define BLOCK_CONNECT_ROTATE_EN to include the saturating rotator and phase counter.
module block_connect #(
    parameter int DW = 16
) (
    input logic           clk,
    input logic           reset,
    block_connect_if.slave bus
);
    localparam int SW = DW + 2;
    localparam logic signed [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] MAX_VAL = {1'b0, {(DW-1){1'b1}}};

    logic signed [DW-1:0] tap_i [0:3];
    logic signed [DW-1:0] tap_q [0:3];
    logic signed [SW-1:0] sum_i;
    logic signed [SW-1:0] sum_q;
    logic signed [DW-1:0] avg_i;
    logic signed [DW-1:0] avg_q;
    logic signed [DW-1:0] y_i;
    logic signed [DW-1:0] y_q;

    function automatic logic signed [SW-1:0] sext(input logic signed [DW-1:0] v);
        return {{2{v[DW-1]}}, v};
    endfunction

    // The only value whose negation overflows is the most negative one.
    function automatic logic signed [DW-1:0] neg_sat(input logic signed [DW-1:0] v);
        return (v == MIN_VAL) ? MAX_VAL : -v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                tap_i[k] <= '0;
                tap_q[k] <= '0;
            end
        end else begin
            tap_i[0] <= bus.x_i;
            tap_q[0] <= bus.x_q;
            for (int k = 3; k > 0; k--) begin
                tap_i[k] <= tap_i[k-1];
                tap_q[k] <= tap_q[k-1];
            end
        end
    end

    always_comb begin
        sum_i = sext(tap_i[0]) + sext(tap_i[1]) + sext(tap_i[2]) + sext(tap_i[3]);
        sum_q = sext(tap_q[0]) + sext(tap_q[1]) + sext(tap_q[2]) + sext(tap_q[3]);
    end

    // Arithmetic shift gives floor division; the quotient always fits in DW bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avg_i <= '0;
            avg_q <= '0;
        end else begin
            avg_i <= DW'(sum_i >>> 2);
            avg_q <= DW'(sum_q >>> 2);
        end
    end

`ifdef BLOCK_CONNECT_ROTATE_EN
    typedef enum logic [1:0] {PH_0, PH_1, PH_2, PH_3} phase_t;

    phase_t               phase;
    phase_t               phase_next;
    logic signed [DW-1:0] rot_i;
    logic signed [DW-1:0] rot_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= PH_0;
        end else begin
            phase <= phase_next;
        end
    end

    // Phase steps every edge; the rotation uses the pre-increment phase.
    always_comb begin
        phase_next = PH_0;
        rot_i      = avg_i;
        rot_q      = avg_q;
        unique case (phase)
            PH_0: begin
                phase_next = PH_1;
            end
            PH_1: begin
                phase_next = PH_2;
                rot_i      = avg_q;
                rot_q      = neg_sat(avg_i);
            end
            PH_2: begin
                phase_next = PH_3;
                rot_i      = neg_sat(avg_i);
                rot_q      = neg_sat(avg_q);
            end
            PH_3: begin
                phase_next = PH_0;
                rot_i      = neg_sat(avg_q);
                rot_q      = avg_i;
            end
            default: begin
                phase_next = PH_0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_i <= '0;
            y_q <= '0;
        end else begin
            y_i <= rot_i;
            y_q <= rot_q;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_i <= '0;
            y_q <= '0;
        end else begin
            y_i <= avg_i;
            y_q <= avg_q;
        end
    end
`endif

    assign bus.y_out_i = y_i;
    assign bus.y_out_q = y_q;
endmodule

// File: tb/tb_block_connect.sv
// Self-checking bench for block_connect: vector table, directed corner sequences and
// randomized traffic against a sample-history reference model.
module tb_block_connect;
    localparam int DW    = 16;
    localparam int SMAX  = 32767;
    localparam int SMIN  = -32768;
    localparam int HLEN  = 4096;

    typedef struct {
        int xi;
        int xq;
        int ei;
        int eq;
    } vec_t;

    logic clk;
    logic reset;

    block_connect_if #(.DW(DW)) bus ();

    block_connect #(.DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int hist_i [0:HLEN-1];
    int hist_q [0:HLEN-1];
    int edge_n;
    int n_cmp;
    int n_bad;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act_i, input int act_q,
                         input int exp_i, input int exp_q);
        n_cmp++;
        if (act_i != exp_i || act_q != exp_q) begin
            n_bad++;
            $display("[TB] FAIL %s edge=%0d got (%0d,%0d) expected (%0d,%0d)",
                     name, edge_n, act_i, act_q, exp_i, exp_q);
        end
    endtask

    function automatic int floor4(input int s);
        int q;
        q = s / 4;
        if ((s % 4) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic int clamp(input int v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    // Output after edge e is the floor mean of samples captured at edges e-5..e-2,
    // multiplied by (-j)^(e mod 4) when the rotator is built in, then clamped.
    task automatic model(input int e, output int yi, output int yq);
        int si;
        int sq;
        int ri;
        int rq;
        int t;
        si = 0;
        sq = 0;
        for (int k = e - 5; k <= e - 2; k++) begin
            if (k >= 0) begin
                si += hist_i[k];
                sq += hist_q[k];
            end
        end
        ri = floor4(si);
        rq = floor4(sq);
`ifdef BLOCK_CONNECT_ROTATE_EN
        for (int r = 0; r < (e % 4); r++) begin
            t  = ri;
            ri = rq;
            rq = -t;
        end
`endif
        yi = clamp(ri);
        yq = clamp(rq);
    endtask

    // Called at a falling edge; drives one sample, clocks it in and checks the output.
    task automatic applyStimulus(input int xi, input int xq, input string name,
                                 output int yi, output int yq);
        int ei;
        int eq;
        bus.x_i = DW'(xi);
        bus.x_q = DW'(xq);
        @(posedge clk);
        hist_i[edge_n] = xi;
        hist_q[edge_n] = xq;
        edge_n++;
        @(negedge clk);
        model(edge_n - 1, ei, eq);
        yi = int'(bus.y_out_i);
        yq = int'(bus.y_out_q);
        check(name, yi, yq, ei, eq);
    endtask

    // Called at a falling edge; asserts reset between edges and holds it for n clocks.
    task automatic checkOutput_reset(input int n, input string name);
        reset = 1'b1;
        #1;
        check({name, "_async"}, int'(bus.y_out_i), int'(bus.y_out_q), 0, 0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check({name, "_hold"}, int'(bus.y_out_i), int'(bus.y_out_q), 0, 0);
        end
        reset  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        vec_t tbl [0:7];
        int   yi;
        int   yq;
        int   cnt;
        int   ri;
        int   rq;

        clk    = 1'b0;
        reset  = 1'b1;
        edge_n = 0;
        n_cmp  = 0;
        n_bad  = 0;
        bus.x_i = 16'sd1234;
        bus.x_q = -16'sd77;

`ifdef BLOCK_CONNECT_ROTATE_EN
        tbl[0] = '{100, -40,    0,    0};
        tbl[1] = '{100, -40,    0,    0};
        tbl[2] = '{100, -40,  -25,   10};
        tbl[3] = '{100, -40,   20,   50};
        tbl[4] = '{100, -40,   75,  -30};
        tbl[5] = '{100, -40,  -40, -100};
        tbl[6] = '{100, -40, -100,   40};
        tbl[7] = '{100, -40,   40,  100};
`else
        tbl[0] = '{100, -40,    0,    0};
        tbl[1] = '{100, -40,    0,    0};
        tbl[2] = '{100, -40,   25,  -10};
        tbl[3] = '{100, -40,   50,  -20};
        tbl[4] = '{100, -40,   75,  -30};
        tbl[5] = '{100, -40,  100,  -40};
        tbl[6] = '{100, -40,  100,  -40};
        tbl[7] = '{100, -40,  100,  -40};
`endif

        #1;
        check("reset_initial", int'(bus.y_out_i), int'(bus.y_out_q), 0, 0);
        @(negedge clk);
        checkOutput_reset(10, "reset_1234");

        for (int v = 0; v < 8; v++) begin
            applyStimulus(tbl[v].xi, tbl[v].xq, "const_model", yi, yq);
            check("const_table", yi, yq, tbl[v].ei, tbl[v].eq);
        end

        // Steady (100,0): period-4 pattern anchored so the first edge after release is p=0.
        checkOutput_reset(2, "rot_reset");
        for (int k = 0; k < 12; k++) begin
            applyStimulus(100, 0, "rot_model", yi, yq);
`ifdef BLOCK_CONNECT_ROTATE_EN
            if (k == 6) check("rot_p2", yi, yq, -100, 0);
            if (k == 7) check("rot_p3", yi, yq, 0, 100);
            if (k == 8) check("rot_p0", yi, yq, 100, 0);
            if (k == 9) check("rot_p1", yi, yq, 0, -100);
`else
            if (k >= 5) check("rot_plain", yi, yq, 100, 0);
`endif
        end

        checkOutput_reset(2, "sat_reset");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(SMIN, SMIN, "sat_model", yi, yq);
`ifdef BLOCK_CONNECT_ROTATE_EN
            if (k == 5) check("sat_p1", yi, yq, SMIN, SMAX);
            if (k == 6) check("sat_p2", yi, yq, SMAX, SMAX);
`else
            if (k >= 5) check("sat_plain", yi, yq, SMIN, SMIN);
`endif
        end

        checkOutput_reset(2, "imp_pos_reset");
        applyStimulus(1, 0, "imp_pos", yi, yq);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, 0, "imp_pos", yi, yq);
            check("imp_pos_zero", yi, yq, 0, 0);
        end

        checkOutput_reset(2, "imp_neg_reset");
        cnt = 0;
        applyStimulus(-1, 0, "imp_neg", yi, yq);
        if (yi == -1) cnt++;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, "imp_neg", yi, yq);
            if (yi == -1) cnt++;
        end
`ifndef BLOCK_CONNECT_ROTATE_EN
        check("imp_neg_count", cnt, 0, 4, 0);
`endif

        checkOutput_reset(2, "ramp_reset");
        for (int k = 0; k < 20; k++) applyStimulus(k, k, "ramp", yi, yq);
        checkOutput_reset(1, "ramp_midreset");
        for (int k = 20; k < 32; k++) applyStimulus(k, k, "ramp_refill", yi, yq);

        checkOutput_reset(2, "rand_reset");
        for (int k = 0; k < 800; k++) begin
            case ($urandom_range(0, 9))
                0:       begin ri = SMIN; rq = SMIN; end
                1:       begin ri = SMAX; rq = SMIN; end
                default: begin
                    ri = int'($urandom_range(0, 65535)) - 32768;
                    rq = int'($urandom_range(0, 65535)) - 32768;
                end
            endcase
            if ($urandom_range(0, 99) == 0) checkOutput_reset(1, "rand_midreset");
            applyStimulus(ri, rq, "random", yi, yq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
